// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: NM masters, NS slaves, round-robin grant held for the whole cycle.
// Define WB_CONBUS_TIMEOUT_EN to add a watchdog that errors out a silent slave after TIMEOUT cycles.
//
// state   | meaning
// ST_IDLE | no grant; next owner picked from last+1 upward
// ST_BUSY | master gnt_idx owns the bus until its cyc drops
module wb_conbus_rr #(
    parameter int NM = 2,
    parameter int NS = 6,
    parameter int S_ADDR_W = 3,
    parameter logic [NS*S_ADDR_W-1:0] S_ADDR = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic [NM-1:0]    gnt_o
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    state;
    logic          busy;
    logic [GW-1:0] gnt_idx, last_idx, nxt_idx, cand;
    logic [31:0]   cur_adr, cur_dat;
    logic [3:0]    cur_sel;
    logic          cur_we, cur_cyc, cur_stb;
    logic          hit, slave_sel, sel_ack, ack_fwd, wd_to;
    logic [SW-1:0] sel_idx;
    logic [31:0]   sel_dat;
    logic          unmapped, err_fire, err_block;
    logic [31:0]   err_adr;
    logic [NM-1:0] err_q;

    assign busy = (state == ST_BUSY);

    // Walk NM..1 so the smallest offset from last+1 is assigned last and wins.
    always_comb begin
        nxt_idx = last_idx;
        cand    = '0;
        for (int i = NM; i >= 1; i--) begin
            cand = GW'((int'(last_idx) + i) % NM);
            if (m_cyc_i[cand]) nxt_idx = cand;
        end
    end

    always_comb begin
        cur_adr = '0;
        cur_dat = '0;
        cur_sel = '0;
        cur_we  = 1'b0;
        cur_cyc = 1'b0;
        cur_stb = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (busy && gnt_idx == GW'(i)) begin
                cur_adr = m_adr_i[i*32 +: 32];
                cur_dat = m_dat_i[i*32 +: 32];
                cur_sel = m_sel_i[i*4 +: 4];
                cur_we  = m_we_i[i];
                cur_cyc = m_cyc_i[i];
                cur_stb = m_stb_i[i];
            end
        end
    end

    // Descending scan: lowest matching slave index takes priority.
    always_comb begin
        hit     = 1'b0;
        sel_idx = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (cur_adr[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
                hit     = 1'b1;
                sel_idx = SW'(k);
            end
        end
    end

    assign slave_sel = cur_cyc & hit;
    assign unmapped  = cur_cyc & cur_stb & ~hit;
    assign err_fire  = unmapped & ~(err_block & (cur_adr == err_adr));

    assign s_adr_o = cur_adr;
    assign s_dat_o = cur_dat;
    assign s_sel_o = cur_sel;
    assign s_we_o  = cur_we;

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        sel_dat = '0;
        sel_ack = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (slave_sel && sel_idx == SW'(k)) begin
                s_cyc_o[k] = 1'b1;
                s_stb_o[k] = cur_stb & ~wd_to;
                sel_dat    = s_dat_i[k*32 +: 32];
                sel_ack    = s_ack_i[k];
            end
        end
        ack_fwd = sel_ack & ~wd_to;
        m_dat_o = sel_dat;
        m_ack_o = '0;
        m_err_o = err_q;
        gnt_o   = '0;
        for (int i = 0; i < NM; i++) begin
            if (busy && gnt_idx == GW'(i)) begin
                gnt_o[i]   = 1'b1;
                m_ack_o[i] = ack_fwd;
                if (wd_to) m_err_o[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt_idx   <= '0;
            last_idx  <= GW'(NM - 1);
            err_q     <= '0;
            err_block <= 1'b0;
            err_adr   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|m_cyc_i) begin
                    state   <= ST_BUSY;
                    gnt_idx <= nxt_idx;
                end
                default: if (!cur_cyc) begin
                    state    <= ST_IDLE;
                    last_idx <= gnt_idx;
                end
            endcase
            err_q <= '0;
            if (err_fire) begin
                err_q[gnt_idx] <= 1'b1;
                err_adr        <= cur_adr;
            end
            err_block <= unmapped & (err_fire | err_block);
        end
    end

`ifdef WB_CONBUS_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_to = cur_cyc & cur_stb & (wd_cnt == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n || !cur_cyc || !cur_stb || ack_fwd || (|err_q) || wd_to)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
    assign wd_to = 1'b0;
`endif

endmodule
